// File: rtl/spi_txn_monitor.sv
// Passive SPI monitor: decodes command/address/data frames seen on the bus into
// valid/ready transaction records with sticky protocol-error flags.
module spi_txn_monitor #(
    parameter logic [7:0]  CMD_WR     = 8'd2,
    parameter logic [7:0]  CMD_RD     = 8'd11,
    parameter int unsigned DUMMY_BITS = 34
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_sdo,
    input  logic        spi_sdi,
    output logic        txn_valid_o,
    input  logic        txn_ready_i,
    output logic        txn_read_o,
    output logic [31:0] txn_addr_o,
    output logic [31:0] txn_data_o,
    output logic [15:0] txn_count_o,
    output logic        err_frame_o,
    output logic        err_cmd_o,
    output logic        err_ovf_o,
    input  logic        clr_err_i
);

    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_DATA  = 3'd4,
        S_SKIP  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sclk_q;
    logic        r_cs_q;
    logic [5:0]  r_bitcnt;
    logic [30:0] r_shift;
    logic        r_is_read;
    logic [31:0] r_addr;
    logic        r_valid;
    logic        r_txn_read;
    logic [31:0] r_txn_addr;
    logic [31:0] r_txn_data;
    logic [15:0] r_count;
    logic        r_err_frame;
    logic        r_err_cmd;
    logic        r_err_ovf;

    logic        w_rise;
    logic        w_cs_fall;
    logic        w_cs_rise;
    logic        w_bit;
    logic [31:0] w_shift_nxt;
    logic        w_op_ok;
    logic        w_run;
    logic        w_shift_en;
    logic        w_cnt_en;
    logic        w_cmd_done;
    logic        w_addr_done;
    logic        w_complete;
    logic        w_set_cmd;
    logic        w_set_frame;
    logic        w_set_ovf;

    assign w_rise      = spi_sclk & ~r_sclk_q;
    assign w_cs_fall   = r_cs_q & ~spi_cs;
    assign w_cs_rise   = spi_cs & ~r_cs_q;
    assign w_bit       = ((r_state == S_DATA) && r_is_read) ? spi_sdi : spi_sdo;
    // The 31 stored bits plus the incoming bit form the full 32-bit word.
    assign w_shift_nxt = {r_shift, w_bit};
    assign w_op_ok     = (w_shift_nxt[7:0] == CMD_WR) || (w_shift_nxt[7:0] == CMD_RD);

    // Edge-detect history for SCLK and CS
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sclk_q <= 1'b0;
            r_cs_q   <= 1'b0;
        end else begin
            r_sclk_q <= spi_sclk;
            r_cs_q   <= spi_cs;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; CS deassertion always wins over a coincident SCLK rise
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_state_nxt = S_CMD;
                else           w_state_nxt = S_IDLE;
            end
            S_CMD: begin
                if (w_cs_rise)                           w_state_nxt = S_IDLE;
                else if (w_rise && r_bitcnt == 6'd7)     w_state_nxt = w_op_ok ? S_ADDR : S_SKIP;
                else                                     w_state_nxt = S_CMD;
            end
            S_ADDR: begin
                if (w_cs_rise)                           w_state_nxt = S_IDLE;
                else if (w_rise && r_bitcnt == 6'd31)    w_state_nxt = r_is_read ? S_DUMMY : S_DATA;
                else                                     w_state_nxt = S_ADDR;
            end
            S_DUMMY: begin
                if (w_cs_rise)                           w_state_nxt = S_IDLE;
                else if (w_rise && r_bitcnt == DUMMY_LAST) w_state_nxt = S_DATA;
                else                                     w_state_nxt = S_DUMMY;
            end
            S_DATA: begin
                if (w_cs_rise)                           w_state_nxt = S_IDLE;
                else if (w_rise && r_bitcnt == 6'd31)    w_state_nxt = S_CMD;
                else                                     w_state_nxt = S_DATA;
            end
            S_SKIP: begin
                if (w_cs_rise) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_SKIP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-cycle strobes derived from the current state
    always_comb begin
        w_run       = w_rise & ~w_cs_rise;
        w_shift_en  = w_run & ((r_state == S_CMD) | (r_state == S_ADDR) | (r_state == S_DATA));
        w_cnt_en    = w_shift_en | (w_run & (r_state == S_DUMMY));
        w_cmd_done  = w_run & (r_state == S_CMD)  & (r_bitcnt == 6'd7);
        w_addr_done = w_run & (r_state == S_ADDR) & (r_bitcnt == 6'd31);
        w_complete  = w_run & (r_state == S_DATA) & (r_bitcnt == 6'd31);
        w_set_cmd   = w_cmd_done & ~w_op_ok;
        w_set_frame = w_cs_rise & (((r_state == S_CMD) & (r_bitcnt != 6'd0)) |
                                   (r_state == S_ADDR) | (r_state == S_DUMMY) | (r_state == S_DATA));
        w_set_ovf   = w_complete & r_valid & ~txn_ready_i;
    end

    // Bit counter, shifter and captured frame fields
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bitcnt  <= 6'd0;
            r_shift   <= 31'd0;
            r_is_read <= 1'b0;
            r_addr    <= 32'd0;
        end else begin
            if (w_state_nxt != r_state) r_bitcnt <= 6'd0;
            else if (w_cnt_en)          r_bitcnt <= r_bitcnt + 6'd1;
            if (w_shift_en)  r_shift   <= w_shift_nxt[30:0];
            if (w_cmd_done)  r_is_read <= (w_shift_nxt[7:0] == CMD_RD);
            if (w_addr_done) r_addr    <= w_shift_nxt;
        end
    end

    // Output record, transaction counter and sticky error flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid     <= 1'b0;
            r_txn_read  <= 1'b0;
            r_txn_addr  <= 32'd0;
            r_txn_data  <= 32'd0;
            r_count     <= 16'd0;
            r_err_frame <= 1'b0;
            r_err_cmd   <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (w_complete && (!r_valid || txn_ready_i)) begin
                r_valid    <= 1'b1;
                r_txn_read <= r_is_read;
                r_txn_addr <= r_addr;
                r_txn_data <= w_shift_nxt;
            end else if (r_valid && txn_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_complete && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
            r_err_frame <= w_set_frame | (r_err_frame & ~clr_err_i);
            r_err_cmd   <= w_set_cmd   | (r_err_cmd   & ~clr_err_i);
            r_err_ovf   <= w_set_ovf   | (r_err_ovf   & ~clr_err_i);
        end
    end

    assign txn_valid_o = r_valid;
    assign txn_read_o  = r_txn_read;
    assign txn_addr_o  = r_txn_addr;
    assign txn_data_o  = r_txn_data;
    assign txn_count_o = r_count;
    assign err_frame_o = r_err_frame;
    assign err_cmd_o   = r_err_cmd;
    assign err_ovf_o   = r_err_ovf;

endmodule

// File: tb/tb_spi_txn_monitor.sv
// Bench for spi_txn_monitor: transaction-level model fed by the frames the bench
// builds, compared against the DUT every cycle, plus directed literal checks.
module tb_spi_txn_monitor;

    localparam logic [7:0] OP_WR = 8'd2;
    localparam logic [7:0] OP_RD = 8'd11;
    localparam int         DUMMY = 34;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_sdo = 1'b0;
    logic        spi_sdi = 1'b0;
    logic        txn_ready_i = 1'b0;
    logic        clr_err_i = 1'b0;
    logic        txn_valid_o;
    logic        txn_read_o;
    logic [31:0] txn_addr_o;
    logic [31:0] txn_data_o;
    logic [15:0] txn_count_o;
    logic        err_frame_o;
    logic        err_cmd_o;
    logic        err_ovf_o;

    int n_pass = 0;
    int n_total = 0;

    // event posted by the stimulus for the clock edge at which the DUT samples it:
    // 1 = record completes, 2 = bad opcode, 3 = CS lost mid-frame
    int          ev_code = 0;
    bit          ev_mute = 1'b0;
    logic        ev_read = 1'b0;
    logic [31:0] ev_addr = 32'd0;
    logic [31:0] ev_data = 32'd0;

    logic        m_valid = 1'b0;
    logic        m_read = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_data = 32'd0;
    logic [15:0] m_count = 16'd0;
    logic        m_ef = 1'b0;
    logic        m_ec = 1'b0;
    logic        m_eo = 1'b0;
    logic        m_drop = 1'b0;

    bit   cmp_on = 1'b0;
    bit   rnd_mode = 1'b0;
    logic man_ready = 1'b0;
    logic man_clr = 1'b0;

    spi_txn_monitor #(.CMD_WR(OP_WR), .CMD_RD(OP_RD), .DUMMY_BITS(DUMMY)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
        .spi_sdo(spi_sdo), .spi_sdi(spi_sdi), .txn_valid_o(txn_valid_o),
        .txn_ready_i(txn_ready_i), .txn_read_o(txn_read_o), .txn_addr_o(txn_addr_o),
        .txn_data_o(txn_data_o), .txn_count_o(txn_count_o), .err_frame_o(err_frame_o),
        .err_cmd_o(err_cmd_o), .err_ovf_o(err_ovf_o), .clr_err_i(clr_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // consumer side: ready/clear either scripted or random
    initial forever begin
        @(posedge clk_i);
        #1;
        if (rnd_mode) begin
            txn_ready_i = ($urandom_range(0, 3) == 0);
            clr_err_i   = ($urandom_range(0, 31) == 0);
        end else begin
            txn_ready_i = man_ready;
            clr_err_i   = man_clr;
        end
    end

    // transaction-level reference: one-entry output buffer plus sticky flags
    initial forever begin
        @(posedge clk_i);
        if (rst_i) begin
            m_valid = 1'b0; m_read = 1'b0; m_addr = 32'd0; m_data = 32'd0;
            m_count = 16'd0; m_ef = 1'b0; m_ec = 1'b0; m_eo = 1'b0;
        end else begin
            m_drop = (ev_code == 1) && m_valid && !txn_ready_i;
            if (ev_code == 1) begin
                if (!m_drop) begin
                    m_valid = 1'b1; m_read = ev_read; m_addr = ev_addr; m_data = ev_data;
                end
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end else if (m_valid && txn_ready_i) begin
                m_valid = 1'b0;
            end
            m_eo = m_drop || (m_eo && !clr_err_i);
            m_ec = (ev_code == 2) || (m_ec && !clr_err_i);
            m_ef = (ev_code == 3) || (m_ef && !clr_err_i);
        end
    end

    // every-cycle comparison against the reference
    initial forever begin
        @(negedge clk_i);
        if (cmp_on) begin
            chk("valid", 32'(txn_valid_o), 32'(m_valid));
            chk("count", 32'(txn_count_o), 32'(m_count));
            chk("err_frame", 32'(err_frame_o), 32'(m_ef));
            chk("err_cmd", 32'(err_cmd_o), 32'(m_ec));
            chk("err_ovf", 32'(err_ovf_o), 32'(m_eo));
            if (m_valid) begin
                chk("read", 32'(txn_read_o), 32'(m_read));
                chk("addr", txn_addr_o, m_addr);
                chk("data", txn_data_o, m_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic spi_bit(input logic o, input logic i, input int ev);
        spi_sclk = 1'b0; spi_sdo = o; spi_sdi = i;
        tick($urandom_range(1, 2));
        spi_sclk = 1'b1;
        ev_code = ev_mute ? 0 : ev;
        tick(1);
        ev_code = 0;
        tick($urandom_range(0, 1));
    endtask

    task automatic cs_low();
        spi_sclk = 1'b0; spi_cs = 1'b0;
        tick(1);
    endtask

    task automatic cs_high(input int ev);
        spi_cs = 1'b1;
        ev_code = ev_mute ? 0 : ev;
        tick(1);
        ev_code = 0;
        tick(1);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                              input int cut_addr, input bit skip_last);
        bit rd;
        bit good;
        rd   = (op == OP_RD);
        good = (op == OP_WR) || rd;
        ev_read = rd; ev_addr = addr; ev_data = data;
        for (int k = 7; k >= 0; k--) spi_bit(op[k], rb(), (k == 0 && !good) ? 2 : 0);
        if (!good) begin
            repeat ($urandom_range(0, 12)) spi_bit(rb(), rb(), 0);
            return;
        end
        for (int k = 31; k >= 0; k--) begin
            if (31 - k == cut_addr) return;
            spi_bit(addr[k], rb(), 0);
        end
        if (rd) repeat (DUMMY) spi_bit(rb(), rb(), 0);
        for (int k = 31; k >= (skip_last ? 1 : 0); k--)
            spi_bit(rd ? rb() : data[k], rd ? data[k] : rb(), (k == 0) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        tick(1);
    endtask

    task automatic drain();
        man_ready = 1'b1;
        tick(3);
        man_ready = 1'b0;
        tick(1);
    endtask

    logic [31:0] a0;
    logic [31:0] d0;
    logic [7:0]  op;

    initial begin
        tick(3);
        cmp_on = 1'b1;
        rst_i = 1'b0;
        tick(1);
        chk("rst_valid", 32'(txn_valid_o), 32'd0);
        chk("rst_read", 32'(txn_read_o), 32'd0);
        chk("rst_addr", txn_addr_o, 32'd0);
        chk("rst_data", txn_data_o, 32'd0);
        chk("rst_count", 32'(txn_count_o), 32'd0);
        chk("rst_errs", 32'({err_frame_o, err_cmd_o, err_ovf_o}), 32'd0);

        // simple write
        cs_low();
        send_frame(OP_WR, 32'd100, 32'd100, -1, 1'b0);
        tick(2);
        chk("wr_valid", 32'(txn_valid_o), 32'd1);
        chk("wr_read", 32'(txn_read_o), 32'd0);
        chk("wr_addr", txn_addr_o, 32'd100);
        chk("wr_data", txn_data_o, 32'd100);
        chk("wr_count", 32'(txn_count_o), 32'd1);
        chk("wr_errs", 32'({err_frame_o, err_cmd_o, err_ovf_o}), 32'd0);
        cs_high(0);
        drain();

        // read with one-cycle latency on the last data rise
        do_reset();
        cs_low();
        send_frame(OP_RD, 32'd100, 32'hDEADBEEF, -1, 1'b1);
        spi_sclk = 1'b0; spi_sdo = rb(); spi_sdi = 1'b1;
        tick(1);
        spi_sclk = 1'b1; ev_code = 1;
        chk("rd_valid_before", 32'(txn_valid_o), 32'd0);
        tick(1);
        ev_code = 0;
        chk("rd_valid_after", 32'(txn_valid_o), 32'd1);
        chk("rd_read", 32'(txn_read_o), 32'd1);
        chk("rd_addr", txn_addr_o, 32'd100);
        chk("rd_data", txn_data_o, 32'hDEADBEEF);
        cs_high(0);
        drain();

        // overflow: write then read under one CS with no consumer
        do_reset();
        a0 = $urandom; d0 = $urandom;
        cs_low();
        send_frame(OP_WR, a0, d0, -1, 1'b0);
        send_frame(OP_RD, $urandom, $urandom, -1, 1'b0);
        tick(2);
        chk("ovf_valid", 32'(txn_valid_o), 32'd1);
        chk("ovf_addr", txn_addr_o, a0);
        chk("ovf_data", txn_data_o, d0);
        chk("ovf_flag", 32'(err_ovf_o), 32'd1);
        chk("ovf_count", 32'(txn_count_o), 32'd2);
        cs_high(0);
        drain();
        chk("ovf_drained", 32'(txn_valid_o), 32'd0);
        man_clr = 1'b1;
        tick(3);
        man_clr = 1'b0;
        tick(1);
        chk("ovf_cleared", 32'(err_ovf_o), 32'd0);

        // bad opcode, then a good frame after CS toggle
        do_reset();
        cs_low();
        send_frame(8'h05, $urandom, $urandom, -1, 1'b0);
        tick(2);
        chk("cmd_err", 32'(err_cmd_o), 32'd1);
        chk("cmd_novalid", 32'(txn_valid_o), 32'd0);
        cs_high(0);
        a0 = $urandom; d0 = $urandom;
        cs_low();
        send_frame(OP_WR, a0, d0, -1, 1'b0);
        tick(1);
        chk("cmd_next_addr", txn_addr_o, a0);
        chk("cmd_next_data", txn_data_o, d0);
        cs_high(0);
        drain();

        // CS lost after 20 address bits
        do_reset();
        cs_low();
        send_frame(OP_WR, $urandom, $urandom, 20, 1'b0);
        cs_high(3);
        chk("frame_err", 32'(err_frame_o), 32'd1);
        chk("frame_norec", 32'(txn_valid_o), 32'd0);
        chk("frame_count", 32'(txn_count_o), 32'd0);
        a0 = $urandom; d0 = $urandom;
        cs_low();
        send_frame(OP_WR, a0, d0, -1, 1'b0);
        tick(1);
        chk("frame_next_valid", 32'(txn_valid_o), 32'd1);
        chk("frame_next_data", txn_data_o, d0);
        cs_high(0);
        drain();

        // reset mid-DATA with CS held low across reset
        do_reset();
        cs_low();
        ev_mute = 1'b1;
        send_frame(OP_WR, $urandom, $urandom, -1, 1'b1);
        do_reset();
        chk("mid_rst_out", 32'({txn_valid_o, txn_read_o, err_frame_o, err_cmd_o, err_ovf_o}), 32'd0);
        chk("mid_rst_addr", txn_addr_o | txn_data_o, 32'd0);
        send_frame(OP_WR, $urandom, $urandom, -1, 1'b0);
        ev_mute = 1'b0;
        tick(2);
        chk("mid_rst_nodecode", 32'(txn_count_o), 32'd0);
        cs_high(0);
        cs_low();
        send_frame(OP_WR, 32'h12345678, 32'hCAFEF00D, -1, 1'b0);
        tick(1);
        chk("mid_rst_recover", txn_data_o, 32'hCAFEF00D);
        cs_high(0);
        drain();

        // randomized traffic against the model
        do_reset();
        rnd_mode = 1'b1;
        cs_low();
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = $urandom_range(0, 19);
            op = (sel < 9) ? OP_WR : (sel < 18) ? OP_RD : 8'($urandom_range(12, 255));
            if (sel == 19) begin
                send_frame(OP_WR, $urandom, $urandom, $urandom_range(1, 31), 1'b0);
                cs_high(3);
                cs_low();
            end else begin
                send_frame(op, $urandom, $urandom, -1, 1'b0);
                if (sel >= 18 || $urandom_range(0, 2) == 0) begin
                    cs_high(0);
                    cs_low();
                end
            end
        end
        cs_high(0);
        rnd_mode = 1'b0;
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_txn_monitor.md
# spi_txn_monitor

Passive SPI bus monitor that sits directly downstream of the stimulus SPI master on the FPGA test setup. It observes SCLK, CS, master data out (SDO) and the DUT's returned data (SDI) and decodes each command/address/data frame. Every completed write or read transaction is presented as one record on a valid/ready port for logging or comparison, together with sticky protocol-error flags. The block never drives the SPI bus.

## Interface
Parameters:
- CMD_WR, 8'd2: write-memory opcode; data phase sampled from spi_sdo.
- CMD_RD, 8'd11: read-memory opcode; dummy phase, then data phase sampled from spi_sdi.
- DUMMY_BITS, 34: dummy clocks between address and read data (range 1-63).

Ports:
- clk_i in 1: FPGA clock. Same clock that generates spi_sclk; all inputs are synchronous to it.
- rst_i in 1: reset, synchronous, active-high.
- spi_sclk in 1: SPI clock; at most half of clk_i.
- spi_cs in 1: SPI chip select, active-low.
- spi_sdo in 1: master-to-DUT data, MSB first.
- spi_sdi in 1: DUT-to-master data, MSB first.
- txn_valid_o out 1: transaction record valid.
- txn_ready_i in 1: consumer accepts record.
- txn_read_o out 1: 1 = read (CMD_RD), 0 = write (CMD_WR).
- txn_addr_o out 32: transaction address.
- txn_data_o out 32: write data or read data.
- txn_count_o out 16: completed transactions, saturating at 16'hFFFF.
- err_frame_o out 1: sticky; CS deasserted mid-frame.
- err_cmd_o out 1: sticky; opcode not CMD_WR or CMD_RD.
- err_ovf_o out 1: sticky; record dropped because the output was full.
- clr_err_i in 1: clears all three error flags.

## Operation
- Input registers: sclk_q and cs_q. Rising edge (rise) = spi_sclk & ~sclk_q. All bits are sampled on rise (the master changes data on falling SCLK).
- States:
  - IDLE: wait for a CS falling edge (cs_q=1, spi_cs=0), then go to CMD with bitcnt=0. cs_q resets to 0, so a CS already low when reset exits does not start a frame. The block waits for CS high first.
  - CMD: shift 8 bits. After the 8th bit: CMD_WR or CMD_RD goes to ADDR; any other opcode sets err_cmd_o and goes to SKIP.
  - ADDR: shift 32 bits. After the 32nd bit: a read goes to DUMMY; a write goes to DATA.
  - DUMMY: count DUMMY_BITS rises and ignore the data, then go to DATA.
  - DATA: shift 32 bits from spi_sdo (write) or spi_sdi (read). After the 32nd bit: complete the record and return to CMD with bitcnt=0. Back-to-back frames under one CS are supported.
  - SKIP: ignore SCLK until CS rises, then go to IDLE.
- CS rising in CMD with bitcnt=0: normal end of frame, go to IDLE, no error.
- CS rising in any other non-IDLE/SKIP state: set err_frame_o, discard the partial record, go to IDLE.
- Bit counter is 6 bits wide. The shift register is 32 bits, shift-left, with the LSB taking the new bit. Opcode = low 8 bits after CMD.
- Record completion:
  - If the output is empty, or txn_ready_i=1 in the same cycle: load the record and assert txn_valid_o.
  - Otherwise: drop the new record and set err_ovf_o.
  - txn_count_o increments on every completed record, dropped or not, and saturates.
- Output holds: txn_valid_o stays high until txn_valid_o & txn_ready_i. Record fields stay stable while valid.
- Error flags: set has priority over clr_err_i in the same cycle.

## Timing
- Reset values: txn_valid_o=0, txn_read_o=0, txn_addr_o=0, txn_data_o=0, txn_count_o=0, all err_*=0, state=IDLE, sclk_q=0, cs_q=0.
- Latency: txn_valid_o rises on the clk_i edge after the cycle in which the final DATA rise is sampled (one cycle).
- Handshake: a record is transferred in any cycle with valid & ready.
  - Completion and acceptance in the same cycle: old record consumed, new record loaded, valid stays 1, no overflow.
- Error flags assert one cycle after the triggering sample.
- Reset mid-frame: the frame is abandoned. No record and no error flag result from it.

## Test plan
- Write 2/addr 100/data 100, CS held low: one record with read=0, addr=32'd100, data=32'd100; count=1; no errors.
- Read 11/addr 100, 34 dummy clocks, DUT drives 32'hDEADBEEF on sdi: record with read=1, addr=100, data=32'hDEADBEEF. Check valid appears 1 cycle after the last rise.
- Write then read under one CS, txn_ready_i=0 throughout: first record held; second dropped; err_ovf_o=1; count=2. Then pulse ready: valid drops. Then pulse clr_err_i: err_ovf_o clears.
- Opcode 8'h05: err_cmd_o=1; no record until CS rises. The next valid frame after CS low decodes normally.
- CS raised after 20 ADDR bits: err_frame_o=1, no record, state IDLE. A following full write frame decodes correctly.
- rst_i asserted mid-DATA with CS low, then released with CS still low: no frame decoded until CS goes high and low again. All outputs 0 after reset.
